// File: rtl/opb_pkg.sv
// rtl/opb_pkg.sv - shared OPB slave types, widths and byte-merge helper
package opb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACK    = 2'd2
  } opb_state_e;

  localparam int OPB_DW  = 32;
  localparam int OPB_BEW = 4;

  // be[b] selects bits [8b+7:8b]; callers map OPB BE[0] (MSB byte) onto be[3].
  function automatic logic [OPB_DW-1:0] byte_merge(input logic [OPB_DW-1:0]  old_v,
                                                   input logic [OPB_DW-1:0]  new_v,
                                                   input logic [OPB_BEW-1:0] be);
    logic [OPB_DW-1:0] res;
    for (int b = 0; b < OPB_BEW; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_swreg_bank.sv
// rtl/opb_swreg_bank.sv - OPB slave bank of 32-bit software registers
module opb_swreg_bank
  import opb_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF,
  parameter int          NREG       = 8,
  parameter logic [31:0] WR_MASK    = 32'h0000_000F
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst_n,
  input  logic [0:31]          OPB_ABus,
  input  logic [0:3]           OPB_BE,
  input  logic [0:31]          OPB_DBus,
  input  logic                 OPB_RNW,
  input  logic                 OPB_select,
  input  logic                 OPB_seqAddr,
  output logic [0:31]          Sl_DBus,
  output logic                 Sl_xferAck,
  output logic                 Sl_errAck,
  output logic                 Sl_retry,
  output logic                 Sl_toutSup,
  output logic [NREG*32-1:0]   user_wr_data,
  output logic [NREG-1:0]      user_wr_strb,
  input  logic [NREG*32-1:0]   user_rd_data
);

  opb_state_e                 state_q, state_d;
  logic [31:0]                off_q;
  logic                       rnw_q;
  logic [OPB_BEW-1:0]         be_q;
  logic [OPB_DW-1:0]          wdata_q;
  logic [NREG-1:0][OPB_DW-1:0] regs_q;
  logic                       xferack_q, errack_q;
  logic [OPB_DW-1:0]          dbus_q;
  logic [NREG-1:0]            strb_q;

  logic [31:0]        abus, offset;
  logic [OPB_DW-1:0]  dbus_in;
  logic [OPB_BEW-1:0] be_in;
  logic               hit, ack_edge, in_range, wr_ok;
  logic [29:0]        idx;
  logic [NREG-1:0]    sel;
  logic [OPB_DW-1:0]  rd_val;
  logic               unused_seq;

  // Big-endian OPB vectors land MSB-first: OPB bit 0 becomes bit 31, BE[0] becomes be[3].
  assign abus    = OPB_ABus;
  assign dbus_in = OPB_DBus;
  assign be_in   = OPB_BE;
  assign unused_seq = OPB_seqAddr;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  assign offset   = abus - C_BASEADDR;
  assign hit      = OPB_select && (offset <= (C_HIGHADDR - C_BASEADDR));
  assign ack_edge = (state_q == DECODE) && OPB_select;
  assign idx      = off_q[31:2];
  assign in_range = (idx < 30'(NREG));

  always_comb begin
    sel    = '0;
    rd_val = '0;
    wr_ok  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == 30'(i)) begin
        sel[i] = 1'b1;
        wr_ok  = WR_MASK[i];
        rd_val = WR_MASK[i] ? regs_q[i] : user_rd_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = DECODE;
      DECODE:  state_d = OPB_select ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q   <= IDLE;
      off_q     <= '0;
      rnw_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      regs_q    <= '0;
      xferack_q <= 1'b0;
      errack_q  <= 1'b0;
      dbus_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      xferack_q <= ack_edge;
      errack_q  <= ack_edge && (!in_range || (!rnw_q && !wr_ok));
      dbus_q    <= (ack_edge && rnw_q) ? rd_val : '0;
      strb_q    <= (ack_edge && !rnw_q && wr_ok) ? sel : '0;
      if (state_q == IDLE && hit) begin
        off_q   <= offset;
        rnw_q   <= OPB_RNW;
        be_q    <= be_in;
        wdata_q <= dbus_in;
      end
      for (int i = 0; i < NREG; i++) begin
        if (ack_edge && !rnw_q && wr_ok && sel[i]) begin
          regs_q[i] <= byte_merge(regs_q[i], wdata_q, be_q);
        end
      end
    end
  end

  assign Sl_DBus      = dbus_q;
  assign Sl_xferAck   = xferack_q;
  assign Sl_errAck    = errack_q;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;
  assign user_wr_data = regs_q;
  assign user_wr_strb = strb_q;

endmodule
